enigma_step_controller: RTL and testbench

ENIGMA_STEP_CONTROLLER -- requirements
Module: enigma_step_controller

---
 rtl/enigma_pkg.sv | 13 +
 rtl/rotor_stepper.sv | 28 ++
 rtl/enigma_step_controller.sv | 116 +++++++++++
 tb/tb_enigma_step_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, FSM state type and rotor position helpers
package enigma_pkg;
  localparam int LETTERS = 26;
  localparam int POS_W = 5;
  localparam logic [POS_W-1:0] INVALID_CODE = 5'b11111;
  typedef enum logic [2:0] {IDLE, STEP, SETTLE, EMIT, RELEASE} state_t;
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p == POS_W'(LETTERS - 1)) ? '0 : p + POS_W'(1);
  endfunction
  function automatic logic [POS_W-1:0] pos_fold(input logic [POS_W-1:0] p);
    return (p > POS_W'(LETTERS - 1)) ? p - POS_W'(LETTERS) : p;
  endfunction
endpackage

// File: rtl/rotor_stepper.sv
// rotor_stepper: combinational next rotor positions for one key press
// Inputs: i_pos_l/m/r current positions, i_notch_r/m turnover positions.
// Outputs: o_next_l/m/r positions after stepping.
// DOUBLE_STEP_EN: middle rotor also steps when it sits on its own notch.
module rotor_stepper
  import enigma_pkg::*;
(
  input  logic [POS_W-1:0] i_pos_l,
  input  logic [POS_W-1:0] i_pos_m,
  input  logic [POS_W-1:0] i_pos_r,
  input  logic [POS_W-1:0] i_notch_r,
  input  logic [POS_W-1:0] i_notch_m,
  output logic [POS_W-1:0] o_next_l,
  output logic [POS_W-1:0] o_next_m,
  output logic [POS_W-1:0] o_next_r
);
  logic w_m_at, w_adv_m, w_adv_l;
  assign w_m_at = i_pos_m == i_notch_m;
`ifdef DOUBLE_STEP_EN
  assign w_adv_m = (i_pos_r == i_notch_r) || w_m_at;
`else
  assign w_adv_m = i_pos_r == i_notch_r;
`endif
  assign w_adv_l = w_adv_m && w_m_at;
  assign o_next_r = pos_inc(i_pos_r);
  assign o_next_m = w_adv_m ? pos_inc(i_pos_m) : i_pos_m;
  assign o_next_l = w_adv_l ? pos_inc(i_pos_l) : i_pos_l;
endmodule

// File: rtl/enigma_step_controller.sv
// enigma_step_controller: key-press sequencing and rotor stepping for an Enigma datapath
// Ports: clock/reset (sync, active-high); key_letter/key_ready keyboard;
// set/set_pos rotor load {L,M,R}; enc_in/enc_out datapath handshake;
// pos_l/m/r rotor positions; out_valid/out_letter/out_ready display;
// busy (not IDLE); err one-cycle error pulse.
// DOUBLE_STEP_EN: enables historical middle-rotor double step.
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int NOTCH_R = 16,
  parameter int NOTCH_M = 4,
  parameter int ENC_LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [LETTERS-1:0]   key_letter,
  input  logic                 key_ready,
  input  logic                 set,
  input  logic [3*POS_W-1:0]   set_pos,
  output logic [LETTERS-1:0]   enc_in,
  input  logic [POS_W-1:0]     enc_out,
  output logic [POS_W-1:0]     pos_l,
  output logic [POS_W-1:0]     pos_m,
  output logic [POS_W-1:0]     pos_r,
  output logic                 out_valid,
  output logic [POS_W-1:0]     out_letter,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err
);
  localparam logic [3:0] LAT_M1 = 4'(ENC_LAT - 1);
  state_t r_state, w_next;
  logic r_key_prev, r_out_valid, r_err;
  logic [LETTERS-1:0] r_enc_in;
  logic [POS_W-1:0] r_pos_l, r_pos_m, r_pos_r, r_out_letter;
  logic [POS_W-1:0] w_next_l, w_next_m, w_next_r;
  logic [3:0] r_cnt;
  logic w_press, w_onehot, w_lat_done, w_bad_code;
  logic w_load, w_capture, w_key_err, w_step, w_sample, w_code_err, w_emit_done;
  assign w_press = key_ready && !r_key_prev;
  assign w_onehot = $onehot(key_letter);
  assign w_lat_done = r_cnt == 4'd0;
  assign w_bad_code = (enc_out == INVALID_CODE) || (enc_out > POS_W'(LETTERS - 1));
  rotor_stepper u_stepper (
    .i_pos_l  (r_pos_l),
    .i_pos_m  (r_pos_m),
    .i_pos_r  (r_pos_r),
    .i_notch_r(POS_W'(NOTCH_R)),
    .i_notch_m(POS_W'(NOTCH_M)),
    .o_next_l (w_next_l),
    .o_next_m (w_next_m),
    .o_next_r (w_next_r)
  );
  always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
  // set takes priority over a press in the same IDLE cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = set ? IDLE : !w_press ? IDLE : w_onehot ? STEP : RELEASE;
      STEP:    w_next = SETTLE;
      SETTLE:  w_next = !w_lat_done ? SETTLE : w_bad_code ? RELEASE : EMIT;
      EMIT:    w_next = out_ready ? RELEASE : EMIT;
      RELEASE: w_next = key_ready ? RELEASE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    w_load = r_state == IDLE && set;
    w_capture = r_state == IDLE && !set && w_press && w_onehot;
    w_key_err = r_state == IDLE && !set && w_press && !w_onehot;
    w_step = r_state == STEP;
    w_sample = r_state == SETTLE && w_lat_done;
    w_code_err = w_sample && w_bad_code;
    w_emit_done = r_state == EMIT && out_ready;
  end
  // key_prev resets high so a key held through reset never counts as a press
  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_prev <= 1'b1;
      r_err <= 1'b0;
      r_enc_in <= '0;
      r_pos_l <= '0;
      r_pos_m <= '0;
      r_pos_r <= '0;
      r_cnt <= '0;
      r_out_letter <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_key_prev <= key_ready;
      r_err <= w_key_err || w_code_err;
      if (w_capture) r_enc_in <= key_letter;
      if (w_load) begin
        r_pos_l <= pos_fold(set_pos[14:10]);
        r_pos_m <= pos_fold(set_pos[9:5]);
        r_pos_r <= pos_fold(set_pos[4:0]);
      end else if (w_step) begin
        r_pos_l <= w_next_l;
        r_pos_m <= w_next_m;
        r_pos_r <= w_next_r;
      end
      r_cnt <= w_step ? LAT_M1 : w_lat_done ? r_cnt : r_cnt - 4'd1;
      if (w_sample && !w_bad_code) begin
        r_out_letter <= enc_out;
        r_out_valid <= 1'b1;
      end else if (w_emit_done) r_out_valid <= 1'b0;
    end
  end
  assign enc_in = r_enc_in;
  assign pos_l = r_pos_l;
  assign pos_m = r_pos_m;
  assign pos_r = r_pos_r;
  assign out_valid = r_out_valid;
  assign out_letter = r_out_letter;
  assign err = r_err;
endmodule

// File: tb/tb_enigma_step_controller.sv
// tb_enigma_step_controller: randomized self-checking bench with a behavioural rotor model
module tb_enigma_step_controller;
  localparam int LAT = 2;
  logic clock = 1'b0, reset = 1'b1, key_ready = 1'b0, set = 1'b0, out_ready = 1'b0;
  logic [25:0] key_letter = '0;
  logic [14:0] set_pos = '0;
  logic [4:0] enc_out = '0;
  logic [25:0] enc_in;
  logic [4:0] pos_l, pos_m, pos_r, out_letter;
  logic out_valid, busy, err;
  int checks = 0, failures = 0;
  int mp_l = 0, mp_m = 0, mp_r = 0;
  logic [25:0] m_enc_in = '0;
  int ob_first_valid, ob_valid_cnt, ob_err_cnt, ob_steps, ob_exp_letter;
  logic [4:0] ob_letter;
  bit ob_unstable;
  logic [25:0] ob_enc_in;

  enigma_step_controller #(.NOTCH_R(16), .NOTCH_M(4), .ENC_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .key_letter(key_letter), .key_ready(key_ready),
    .set(set), .set_pos(set_pos), .enc_in(enc_in), .enc_out(enc_out),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .out_valid(out_valid),
    .out_letter(out_letter), .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic model_step();
    bit m_at, adv_m, adv_l;
    m_at = mp_m == 4;
    adv_m = mp_r == 16;
`ifdef DOUBLE_STEP_EN
    adv_m = adv_m || m_at;
`endif
    adv_l = adv_m && m_at;
    mp_r = (mp_r + 1) % 26;
    if (adv_m) mp_m = (mp_m + 1) % 26;
    if (adv_l) mp_l = (mp_l + 1) % 26;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; key_ready = 1'b0; set = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mp_l = 0; mp_m = 0; mp_r = 0; m_enc_in = '0;
  endtask

  task automatic set_positions(input int l, input int m, input int r);
    @(negedge clock);
    set = 1'b1;
    set_pos = {5'(l), 5'(m), 5'(r)};
    @(negedge clock);
    set = 1'b0;
    mp_l = l > 25 ? l - 26 : l;
    mp_m = m > 25 ? m - 26 : m;
    mp_r = r > 25 ? r - 26 : r;
  endtask

  // One key press; enc_out changes every cycle so the sampled value reveals the sample edge.
  task automatic op(input logic [25:0] keyv, input bit bad, input int rdy, input int hold, input bit set_mid);
    int base, total;
    logic [14:0] prev;
    base = $urandom_range(0, 25);
    total = hold + LAT + rdy + 8;
    ob_first_valid = -1; ob_valid_cnt = 0; ob_err_cnt = 0; ob_steps = 0; ob_unstable = 0;
    ob_letter = '0;
    ob_exp_letter = (base + 7 * (LAT + 1)) % 26;
    @(negedge clock);
    key_letter = keyv; key_ready = 1'b1; out_ready = 1'b0; set = 1'b0; enc_out = 5'(base);
    prev = {pos_l, pos_m, pos_r};
    for (int k = 0; k < total; k++) begin
      @(negedge clock);
      if (out_valid) begin
        if (ob_first_valid < 0) begin
          ob_first_valid = k;
          ob_letter = out_letter;
        end else if (out_letter !== ob_letter) ob_unstable = 1;
        ob_valid_cnt++;
      end
      if (err) ob_err_cnt++;
      if ({pos_l, pos_m, pos_r} !== prev) ob_steps++;
      prev = {pos_l, pos_m, pos_r};
      if (k == 0) ob_enc_in = enc_in;
      enc_out = (bad && k == LAT) ? 5'($urandom_range(26, 31)) : 5'((base + 7 * (k + 1)) % 26);
      out_ready = (k + 1) >= rdy;
      key_ready = (k + 1) < hold;
      set = set_mid && k == 1;
      if (set) set_pos = 15'($urandom);
    end
    key_ready = 1'b0; out_ready = 1'b0; set = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    checks++;
    if ({pos_l, pos_m, pos_r} !== 15'd0) begin
      failures++;
      $display("FAIL reset_pos got=%0d/%0d/%0d exp=0/0/0", pos_l, pos_m, pos_r);
    end
    checks++;
    if (enc_in !== 26'd0 || out_letter !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got enc_in=%h letter=%0d valid=%b exp 0/0/0", enc_in, out_letter, out_valid);
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got err=%b busy=%b exp 0/0", err, busy);
    end
    @(negedge clock);
    reset = 1'b1; key_ready = 1'b1; key_letter = 26'd1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || pos_r !== 5'd0) begin
      failures++;
      $display("FAIL held_through_reset got busy=%b pos_r=%0d exp busy=0 pos_r=0", busy, pos_r);
    end
    key_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic();
    set_positions(0, 0, 0);
    op(26'd1, 0, 0, 2, 0);
    model_step();
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'(mp_l), 5'(mp_m), 5'(mp_r)} || mp_r != 1) begin
      failures++;
      $display("FAIL basic_pos got=%0d/%0d/%0d exp=%0d/%0d/%0d", pos_l, pos_m, pos_r, mp_l, mp_m, mp_r);
    end
    checks++;
    if (ob_first_valid != LAT + 1) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", ob_first_valid, LAT + 1);
    end
    checks++;
    if (ob_letter !== 5'(ob_exp_letter)) begin
      failures++;
      $display("FAIL basic_letter got=%0d exp=%0d", ob_letter, ob_exp_letter);
    end
    checks++;
    if (ob_enc_in !== 26'd1 || ob_err_cnt != 0) begin
      failures++;
      $display("FAIL basic_enc_in got=%h err=%0d exp=%h err=0", ob_enc_in, ob_err_cnt, 26'd1);
    end
    m_enc_in = 26'd1;
  endtask

  task automatic test_notch();
    set_positions(0, 4, 16);
    op(26'd1 << 5, 0, 1, 2, 0);
    model_step();
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd1, 5'd5, 5'd17} || mp_l != 1 || mp_m != 5) begin
      failures++;
      $display("FAIL notch got=%0d/%0d/%0d exp=1/5/17", pos_l, pos_m, pos_r);
    end
    m_enc_in = 26'd1 << 5;
  endtask

  task automatic test_double();
    logic [14:0] exp;
`ifdef DOUBLE_STEP_EN
    exp = {5'd1, 5'd5, 5'd6};
`else
    exp = {5'd0, 5'd4, 5'd6};
`endif
    set_positions(0, 4, 5);
    op(26'd1 << 9, 0, 0, 3, 0);
    model_step();
    checks++;
    if ({pos_l, pos_m, pos_r} !== exp || {5'(mp_l), 5'(mp_m), 5'(mp_r)} !== exp) begin
      failures++;
      $display("FAIL double_step got=%0d/%0d/%0d exp=%0d/%0d/%0d", pos_l, pos_m, pos_r, exp[14:10], exp[9:5], exp[4:0]);
    end
    m_enc_in = 26'd1 << 9;
  endtask

  task automatic test_wrap();
    set_positions(25, 25, 25);
    op(26'd1 << 25, 0, 0, 2, 0);
    model_step();
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd0}) begin
      failures++;
      $display("FAIL wrap got=%0d/%0d/%0d exp=25/25/0", pos_l, pos_m, pos_r);
    end
    m_enc_in = 26'd1 << 25;
    set_positions(26, 30, 31);
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd4, 5'd5}) begin
      failures++;
      $display("FAIL set_fold got=%0d/%0d/%0d exp=0/4/5", pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_stall_hold();
    op(26'd1 << 3, 0, LAT + 13, 100, 0);
    model_step();
    checks++;
    if (ob_valid_cnt != 12 || ob_unstable) begin
      failures++;
      $display("FAIL stall got valid_cycles=%0d unstable=%0d exp 12/0", ob_valid_cnt, ob_unstable);
    end
    checks++;
    if (ob_steps != 1 || {pos_l, pos_m, pos_r} !== {5'(mp_l), 5'(mp_m), 5'(mp_r)}) begin
      failures++;
      $display("FAIL held_key got steps=%0d pos_r=%0d exp steps=1 pos_r=%0d", ob_steps, pos_r, mp_r);
    end
    m_enc_in = 26'd1 << 3;
  endtask

  task automatic test_errors();
    op(26'd1 << 7, 1, 0, 3, 0);
    model_step();
    checks++;
    if (ob_err_cnt != 1 || ob_first_valid != -1 || ob_steps != 1) begin
      failures++;
      $display("FAIL bad_code got err=%0d first_valid=%0d steps=%0d exp 1/-1/1", ob_err_cnt, ob_first_valid, ob_steps);
    end
    m_enc_in = 26'd1 << 7;
    op((26'd1 << 2) | (26'd1 << 11), 0, 0, 3, 0);
    checks++;
    if (ob_err_cnt != 1 || ob_first_valid != -1 || ob_steps != 0 || enc_in !== m_enc_in) begin
      failures++;
      $display("FAIL two_keys got err=%0d first_valid=%0d steps=%0d exp 1/-1/0", ob_err_cnt, ob_first_valid, ob_steps);
    end
    op(26'd0, 0, 0, 2, 0);
    checks++;
    if (ob_err_cnt != 1 || ob_steps != 0) begin
      failures++;
      $display("FAIL zero_keys got err=%0d steps=%0d exp 1/0", ob_err_cnt, ob_steps);
    end
  endtask

  task automatic test_set_wins();
    @(negedge clock);
    key_letter = 26'd1 << 1; key_ready = 1'b1; set = 1'b1; set_pos = {5'd3, 5'd7, 5'd9};
    @(negedge clock);
    set = 1'b0;
    mp_l = 3; mp_m = 7; mp_r = 9;
    repeat (3) @(negedge clock);
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd3, 5'd7, 5'd9} || busy !== 1'b0 || enc_in !== m_enc_in) begin
      failures++;
      $display("FAIL set_wins got=%0d/%0d/%0d busy=%b exp=3/7/9 busy=0", pos_l, pos_m, pos_r, busy);
    end
    key_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_set_busy();
    op(26'd1 << 12, 0, 2, 2, 1);
    model_step();
    checks++;
    if (ob_steps != 1 || {pos_l, pos_m, pos_r} !== {5'(mp_l), 5'(mp_m), 5'(mp_r)}) begin
      failures++;
      $display("FAIL set_busy got=%0d/%0d/%0d steps=%0d exp=%0d/%0d/%0d steps=1", pos_l, pos_m, pos_r, ob_steps, mp_l, mp_m, mp_r);
    end
    m_enc_in = 26'd1 << 12;
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    @(negedge clock);
    key_letter = 26'd1 << 4; key_ready = 1'b1; out_ready = 1'b0; enc_out = 5'd7;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort_reach_emit got out_valid=0 exp 1 within 20 cycles");
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || {pos_l, pos_m, pos_r} !== 15'd0) begin
      failures++;
      $display("FAIL abort got valid=%b err=%b busy=%b pos_r=%0d exp 0/0/0/0", out_valid, err, busy, pos_r);
    end
    reset = 1'b0; key_ready = 1'b0;
    repeat (2) @(negedge clock);
    mp_l = 0; mp_m = 0; mp_r = 0; m_enc_in = '0;
  endtask

  task automatic test_random();
    logic [25:0] keyv;
    bit valid_key, bad;
    int rdy, a, b, exp_err, exp_cnt;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0)
        set_positions($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      a = $urandom_range(0, 25);
      b = (a + $urandom_range(1, 25)) % 26;
      valid_key = $urandom_range(0, 5) != 0;
      keyv = valid_key ? (26'd1 << a) : ($urandom_range(0, 1) ? 26'd0 : ((26'd1 << a) | (26'd1 << b)));
      bad = valid_key && $urandom_range(0, 5) == 0;
      rdy = $urandom_range(0, 6);
      op(keyv, bad, rdy, $urandom_range(1, 6), valid_key && $urandom_range(0, 1));
      if (valid_key) begin
        model_step();
        m_enc_in = keyv;
      end
      exp_err = (!valid_key || bad) ? 1 : 0;
      checks++;
      if ({pos_l, pos_m, pos_r} !== {5'(mp_l), 5'(mp_m), 5'(mp_r)}) begin
        failures++;
        $display("FAIL rand_pos[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, pos_l, pos_m, pos_r, mp_l, mp_m, mp_r);
      end
      checks++;
      if (ob_err_cnt != exp_err || enc_in !== m_enc_in || busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_err[%0d] got err=%0d enc_in=%h busy=%b exp err=%0d enc_in=%h busy=0", it, ob_err_cnt, enc_in, busy, exp_err, m_enc_in);
      end
      exp_cnt = (rdy > LAT + 2 ? rdy : LAT + 2) - LAT - 1;
      checks++;
      if (exp_err == 1 ? ob_first_valid != -1 :
          (ob_first_valid != LAT + 1 || ob_letter !== 5'(ob_exp_letter) || ob_valid_cnt != exp_cnt || ob_unstable)) begin
        failures++;
        $display("FAIL rand_out[%0d] got first=%0d letter=%0d cycles=%0d exp first=%0d letter=%0d cycles=%0d",
                 it, ob_first_valid, ob_letter, ob_valid_cnt, exp_err ? -1 : LAT + 1, ob_exp_letter, exp_cnt);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_notch();
    test_double();
    test_wrap();
    test_stall_hold();
    test_errors();
    test_set_wins();
    test_set_busy();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
